// File: rtl/irq_stim_gen.sv
// -----------------------------------------------------------------------------
// irq_stim_gen
//
// Interrupt stimulus generator for the nanorv32 test wrappers. NUM_CH
// independent channels, each with its own period, mode and target irq bit,
// drive a registered irq vector towards the core. Level-mode channels hold a
// pending flag that the core clears through irq_ack.
//
// Modes: 0 = off, 1 = periodic pulse, 2 = periodic level, 3 = one-shot pulse.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   enable      global run; low freezes every channel counter
//   cfg_valid   configuration write request
//   cfg_ready   high from the first clock edge after reset release onwards
//   cfg_ch      channel to configure
//   cfg_mode    channel mode
//   cfg_period  firing period in enabled cycles (0 = never fires)
//   cfg_bit     irq bit driven by the channel
//   cfg_err     one-cycle pulse after a write to a non-existent channel
//   irq_ack     per-bit acknowledge, clears level-mode pending
//   irq         registered interrupt lines
//   fire_cnt    wrapping count of all fire events over all channels
//
// Optional feature, enabled by defining IRQ_STIM_OVERRUN_EN:
//   ovr_cnt     per-channel 8-bit saturating overrun counters, ch0 in LSBs
//   overrun     sticky flag, set by any overrun, cleared only by reset
// -----------------------------------------------------------------------------
module irq_stim_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int IRQ_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BIT_W = (IRQ_W > 1) ? $clog2(IRQ_W) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [BIT_W-1:0]    cfg_bit,
    output logic                cfg_err,
    input  logic [IRQ_W-1:0]    irq_ack,
    output logic [IRQ_W-1:0]    irq,
`ifdef IRQ_STIM_OVERRUN_EN
    output logic [NUM_CH*8-1:0] ovr_cnt,
    output logic                overrun,
`endif
    output logic [31:0]         fire_cnt
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_PULSE   = 2'd1,
        MODE_LEVEL   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    // Per-channel configuration and run state
    mode_t            ch_mode   [NUM_CH];
    logic [CNT_W-1:0] ch_period [NUM_CH];
    logic [BIT_W-1:0] ch_bit    [NUM_CH];
    logic [CNT_W-1:0] ch_cnt    [NUM_CH];
    logic [NUM_CH-1:0] ch_pend;

    logic              cfg_accept;
    logic              cfg_bad_ch;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] cnt_adv;
    logic [NUM_CH-1:0] cnt_end;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] ack_hit;
    logic [NUM_CH-1:0] pend_nxt;
    logic [IRQ_W-1:0]  irq_nxt;
    logic [31:0]       fire_sum;

    assign cfg_accept = cfg_valid && cfg_ready;
    // Widen before comparing so the check stays meaningful when NUM_CH is
    // not a power of two and cannot be constant-folded away otherwise.
    assign cfg_bad_ch = (32'(cfg_ch) >= 32'(NUM_CH));

    // Per-channel fire decision, next pending state and the irq vector that
    // will be registered on the coming edge. A write to a channel suppresses
    // its fire in the same cycle. irq uses the next pending value so a level
    // fire shows up with the same single-cycle latency as a pulse, and an
    // ack drops the line on the following cycle.
    always_comb begin
        wr_hit   = '0;
        cnt_adv  = '0;
        cnt_end  = '0;
        fire     = '0;
        pulse    = '0;
        ack_hit  = '0;
        pend_nxt = '0;
        irq_nxt  = '0;
        fire_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit[c]  = cfg_accept && !cfg_bad_ch && (32'(cfg_ch) == 32'(c));
            cnt_adv[c] = enable && (ch_mode[c] != MODE_OFF) && (ch_period[c] != '0);
            cnt_end[c] = (ch_cnt[c] == (ch_period[c] - CNT_W'(1)));
            fire[c]    = cnt_adv[c] && cnt_end[c] && !wr_hit[c];
            pulse[c]   = fire[c] && ((ch_mode[c] == MODE_PULSE) || (ch_mode[c] == MODE_ONESHOT));

            for (int b = 0; b < IRQ_W; b++) begin
                if (ch_bit[c] == BIT_W'(b)) begin
                    ack_hit[c] = irq_ack[b];
                end
            end

            // Fire beats ack; a config write beats both.
            if (wr_hit[c]) begin
                pend_nxt[c] = 1'b0;
            end else if (fire[c] && (ch_mode[c] == MODE_LEVEL)) begin
                pend_nxt[c] = 1'b1;
            end else if (ack_hit[c]) begin
                pend_nxt[c] = 1'b0;
            end else begin
                pend_nxt[c] = ch_pend[c];
            end

            for (int b = 0; b < IRQ_W; b++) begin
                if ((ch_bit[c] == BIT_W'(b)) && (pulse[c] || pend_nxt[c])) begin
                    irq_nxt[b] = 1'b1;
                end
            end

            fire_sum = fire_sum + 32'(fire[c]);
        end
    end

    // Channel state, irq register, handshake flags and fire counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            irq       <= '0;
            fire_cnt  <= '0;
            ch_pend   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_mode[c]   <= MODE_OFF;
                ch_period[c] <= '0;
                ch_bit[c]    <= '0;
                ch_cnt[c]    <= '0;
            end
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_accept && cfg_bad_ch;
            irq       <= irq_nxt;
            fire_cnt  <= fire_cnt + fire_sum;
            ch_pend   <= pend_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c]) begin
                    ch_mode[c]   <= mode_t'(cfg_mode);
                    ch_period[c] <= cfg_period;
                    ch_bit[c]    <= cfg_bit;
                    ch_cnt[c]    <= '0;
                end else if (cnt_adv[c]) begin
                    ch_cnt[c] <= cnt_end[c] ? '0 : (ch_cnt[c] + CNT_W'(1));
                    // One-shot retires itself on its only fire.
                    if (fire[c] && (ch_mode[c] == MODE_ONESHOT)) begin
                        ch_mode[c] <= MODE_OFF;
                    end
                end
            end
        end
    end

`ifdef IRQ_STIM_OVERRUN_EN
    logic [7:0]        ovr_q [NUM_CH];
    logic [NUM_CH-1:0] ovr_hit;

    // An overrun is a level fire landing on a still-pending, un-acked flag.
    always_comb begin
        ovr_hit = '0;
        ovr_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ovr_hit[c]         = fire[c] && (ch_mode[c] == MODE_LEVEL) && ch_pend[c] && !ack_hit[c];
            ovr_cnt[c*8 +: 8]  = ovr_q[c];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                ovr_q[c] <= '0;
            end
        end else begin
            overrun <= overrun || (|ovr_hit);
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c]) begin
                    ovr_q[c] <= '0;
                end else if (ovr_hit[c] && (ovr_q[c] != 8'hFF)) begin
                    ovr_q[c] <= ovr_q[c] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_irq_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_irq_stim_gen
//
// Self-checking bench for irq_stim_gen. A behavioural model counts enabled
// cycles since each channel was configured and fires whenever that count is a
// multiple of the period; every scenario compares the DUT against it or
// against fixed expectations. Five channels are instantiated so that an
// out-of-range channel index exists on the 3-bit cfg_ch port.
// -----------------------------------------------------------------------------
module tb_irq_stim_gen;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 16;
    localparam int IRQ_W  = 32;
    localparam int CH_W   = 3;
    localparam int BIT_W  = 5;

    logic                clk;
    logic                resetn;
    logic                enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_mode;
    logic [CNT_W-1:0]    cfg_period;
    logic [BIT_W-1:0]    cfg_bit;
    logic                cfg_err;
    logic [IRQ_W-1:0]    irq_ack;
    logic [IRQ_W-1:0]    irq;
    logic [31:0]         fire_cnt;
`ifdef IRQ_STIM_OVERRUN_EN
    logic [NUM_CH*8-1:0] ovr_cnt;
    logic                overrun;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int          m_mode    [NUM_CH];
    int          m_period  [NUM_CH];
    int          m_bit     [NUM_CH];
    longint      m_elapsed [NUM_CH];
    bit          m_pend    [NUM_CH];
    logic [31:0] m_irq;
    logic [31:0] m_fire;
    logic        m_err;
    logic        m_ready;

    irq_stim_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .IRQ_W (IRQ_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .cfg_bit   (cfg_bit),
        .cfg_err   (cfg_err),
        .irq_ack   (irq_ack),
        .irq       (irq),
`ifdef IRQ_STIM_OVERRUN_EN
        .ovr_cnt   (ovr_cnt),
        .overrun   (overrun),
`endif
        .fire_cnt  (fire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_period[c] = 0; m_bit[c] = 0; m_elapsed[c] = 0; m_pend[c] = 0;
        end
        m_irq = '0; m_fire = '0; m_err = 1'b0; m_ready = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_tick();
        logic [31:0] nirq;
        int nf;
        bit acc;
        nirq = '0;
        nf = 0;
        acc = cfg_valid && m_ready;
        for (int c = 0; c < NUM_CH; c++) begin
            bit fired;
            bit ack;
            fired = 0;
            ack = irq_ack[m_bit[c]];
            if (acc && int'(cfg_ch) == c) begin
                m_mode[c] = int'(cfg_mode); m_period[c] = int'(cfg_period);
                m_bit[c] = int'(cfg_bit); m_elapsed[c] = 0; m_pend[c] = 0;
            end else begin
                if (enable && m_mode[c] != 0 && m_period[c] != 0) begin
                    m_elapsed[c]++;
                    if (m_elapsed[c] % m_period[c] == 0) fired = 1;
                end
                if (fired) nf++;
                if (m_mode[c] == 1 && fired) nirq[m_bit[c]] = 1'b1;
                if (m_mode[c] == 3 && fired) begin
                    nirq[m_bit[c]] = 1'b1; m_mode[c] = 0; m_elapsed[c] = 0;
                end
                if (m_mode[c] == 2 && fired) m_pend[c] = 1;
                else if (ack) m_pend[c] = 0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) if (m_pend[c]) nirq[m_bit[c]] = 1'b1;
        m_irq = nirq;
        m_fire = m_fire + 32'(nf);
        m_err = acc && (int'(cfg_ch) >= NUM_CH);
        m_ready = 1'b1;
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int ch, input int mode, input int period, input int bitn);
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = 2'(mode);
        cfg_period = CNT_W'(period); cfg_bit = BIT_W'(bitn);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_period = '0; cfg_bit = '0; irq_ack = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (irq !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_irq: got %h want 0", irq); end
        n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 0", cfg_ready); end
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", cfg_err); end
        n_total++; if (fire_cnt !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_fire_cnt: got %0d want 0", fire_cnt); end
        resetn = 1'b1;
        step();
        n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ready_after_release: got %b want 1", cfg_ready); end
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_total++; if (irq !== 32'h0) begin n_bad++; $display("[TB] FAIL idle_irq cyc %0d: got %h want 0", i, irq); end
        end
        n_total++; if (fire_cnt !== 32'h0) begin n_bad++; $display("[TB] FAIL idle_fire_cnt: got %0d want 0", fire_cnt); end
    endtask

    task automatic test_pulse();
        logic [31:0] base;
        int first;
        first = -1;
        write_cfg(0, 1, 8, 4);
        base = m_fire;
        for (int i = 1; i <= 80; i++) begin
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL pulse_irq cyc %0d: got %h want %h", i, irq, m_irq); end
            if (first < 0 && irq[4]) first = i;
        end
        n_total++; if (first != 8) begin n_bad++; $display("[TB] FAIL pulse_first: got %0d want 8", first); end
        n_total++; if (fire_cnt !== base + 32'd10) begin n_bad++; $display("[TB] FAIL pulse_fire_cnt: got %0d want %0d", fire_cnt, base + 32'd10); end
    endtask

    task automatic test_level();
        write_cfg(1, 2, 5, 7);
        for (int i = 0; i < 12; i++) begin
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL level_irq cyc %0d: got %h want %h", i, irq, m_irq); end
        end
        n_total++; if (irq[7] !== 1'b1) begin n_bad++; $display("[TB] FAIL level_held: got %b want 1", irq[7]); end
        // Ack on a cycle where the channel does not fire
        if ((m_elapsed[1] + 1) % 5 == 0) step();
        irq_ack[7] = 1'b1;
        step();
        irq_ack[7] = 1'b0;
        n_total++; if (irq[7] !== 1'b0) begin n_bad++; $display("[TB] FAIL level_ack_drop: got %b want 0", irq[7]); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL level_rearm cyc %0d: got %h want %h", i, irq, m_irq); end
        end
        // Ack coinciding with a fire: fire wins
        for (int i = 0; i < 5; i++) if ((m_elapsed[1] + 1) % 5 != 0) step();
        irq_ack[7] = 1'b1;
        step();
        irq_ack[7] = 1'b0;
        n_total++; if (irq[7] !== 1'b1) begin n_bad++; $display("[TB] FAIL level_ack_vs_fire: got %b want 1", irq[7]); end
    endtask

    task automatic test_oneshot();
        int pulses;
        pulses = 0;
        write_cfg(2, 3, 3, 0);
        for (int i = 0; i < 55; i++) begin
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL oneshot_irq cyc %0d: got %h want %h", i, irq, m_irq); end
            if (irq[0]) pulses++;
        end
        n_total++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL oneshot_count: got %0d want 1", pulses); end
        write_cfg(NUM_CH, 1, 1, 0);
        n_total++; if (cfg_err !== 1'b1) begin n_bad++; $display("[TB] FAIL bad_ch_err: got %b want 1", cfg_err); end
        step();
        n_total++; if (cfg_err !== 1'b0) begin n_bad++; $display("[TB] FAIL bad_ch_err_width: got %b want 0", cfg_err); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL bad_ch_nochange cyc %0d: got %h want %h", i, irq, m_irq); end
        end
    endtask

    task automatic test_enable_shared();
        logic [31:0] f0;
        enable = 1'b0;
        write_cfg(0, 1, 4, 5);
        write_cfg(3, 1, 4, 5);
        write_cfg(1, 0, 0, 0);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i >= 10 && i < 16) enable = 1'b0; else enable = 1'b1;
            f0 = m_fire;
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL shared_irq cyc %0d: got %h want %h", i, irq, m_irq); end
            n_total++; if (fire_cnt !== m_fire) begin n_bad++; $display("[TB] FAIL shared_fire_cnt cyc %0d: got %0d want %0d", i, fire_cnt, m_fire); end
            if (i >= 10 && i < 16) begin
                n_total++; if (irq[5] !== 1'b0) begin n_bad++; $display("[TB] FAIL disabled_pulse cyc %0d: got %b want 0", i, irq[5]); end
            end
            if (m_irq[5]) begin
                n_total++; if (fire_cnt !== f0 + 32'd2) begin n_bad++; $display("[TB] FAIL shared_add2 cyc %0d: got %0d want %0d", i, fire_cnt, f0 + 32'd2); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_ch     = CH_W'($urandom_range(0, 7));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = CNT_W'($urandom_range(0, 6));
            cfg_bit    = BIT_W'($urandom_range(0, 7));
            enable     = ($urandom_range(0, 7) != 0);
            irq_ack    = '0;
            irq_ack[7:0] = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step();
            n_total++; if (irq !== m_irq) begin n_bad++; $display("[TB] FAIL rand_irq cyc %0d: got %h want %h", i, irq, m_irq); end
            n_total++; if (fire_cnt !== m_fire) begin n_bad++; $display("[TB] FAIL rand_fire_cnt cyc %0d: got %0d want %0d", i, fire_cnt, m_fire); end
            n_total++; if (cfg_err !== m_err) begin n_bad++; $display("[TB] FAIL rand_err cyc %0d: got %b want %b", i, cfg_err, m_err); end
        end
        cfg_valid = 1'b0; irq_ack = '0; enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        write_cfg(4, 1, 1, 3);
        step();
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        n_total++; if (irq !== 32'h0) begin n_bad++; $display("[TB] FAIL midreset_irq: got %h want 0", irq); end
        n_total++; if (fire_cnt !== 32'h0) begin n_bad++; $display("[TB] FAIL midreset_fire_cnt: got %0d want 0", fire_cnt); end
        n_total++; if (cfg_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_ready: got %b want 0", cfg_ready); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (irq !== 32'h0) begin n_bad++; $display("[TB] FAIL postreset_irq cyc %0d: got %h want 0", i, irq); end
        end
        n_total++; if (cfg_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL postreset_ready: got %b want 1", cfg_ready); end
    endtask

`ifdef IRQ_STIM_OVERRUN_EN
    task automatic test_overrun();
        irq_ack = '0;
        write_cfg(1, 2, 2, 9);
        repeat (600) step();
        n_total++; if (ovr_cnt[15:8] !== 8'd255) begin n_bad++; $display("[TB] FAIL ovr_saturate: got %0d want 255", ovr_cnt[15:8]); end
        n_total++; if (overrun !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_flag: got %b want 1", overrun); end
        write_cfg(1, 2, 2, 9);
        n_total++; if (ovr_cnt[15:8] !== 8'd0) begin n_bad++; $display("[TB] FAIL ovr_clear: got %0d want 0", ovr_cnt[15:8]); end
        n_total++; if (overrun !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_sticky: got %b want 1", overrun); end
    endtask
`endif

    initial begin
        test_reset();
        test_pulse();
        test_level();
        test_oneshot();
        test_enable_shared();
        test_random();
        test_reset_mid();
`ifdef IRQ_STIM_OVERRUN_EN
        test_overrun();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_stim_gen.md
Name: irq_stim_gen

Overview:
Synthesizable, parametrised interrupt stimulus generator for the nanorv32 test wrappers. It replaces fixed cycle-count IRQ patterns with NUM_CH independently programmable channels. Each channel has its own period, mode and target IRQ bit. It sits between the bench/wrapper configuration logic and the core's irq input, and takes per-bit acknowledge from the core side.

Parameters:
NUM_CH, 4, number of stimulus channels (1..16)
CNT_W, 16, period counter width in bits
IRQ_W, 32, width of irq output and irq_ack input
CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridden)
BIT_W, $clog2(IRQ_W), target bit index width (derived)

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
enable  in  1  global run; low freezes all counters
cfg_valid  in  1  configuration write request
cfg_ready  out  1  configuration write can be accepted
cfg_ch  in  CH_W  channel to configure
cfg_mode  in  2  0=off, 1=periodic pulse, 2=periodic level, 3=one-shot pulse
cfg_period  in  CNT_W  firing period in enabled cycles
cfg_bit  in  BIT_W  irq bit driven by this channel
cfg_err  out  1  1-cycle pulse: write with cfg_ch >= NUM_CH
irq_ack  in  IRQ_W  per-bit acknowledge; clears level-mode pending
irq  out  IRQ_W  registered interrupt lines to core
fire_cnt  out  32  total fire events, all channels, wrapping

Behaviour:
- Interface: one clock, clk; reset resetn is asynchronous and active-low.
- Reset values: irq=0, cfg_ready=0, cfg_err=0, fire_cnt=0. All channels: mode=off, counter=0, pending=0, bit=0, period=0.
- cfg_ready goes high on the first clk edge after resetn deasserts, then stays high.
- A write is accepted on a clk edge with cfg_valid && cfg_ready.
- Accepted write to a valid channel, taking effect next cycle:
  - load mode/period/bit
  - counter=0
  - pending=0
- Accepted write with cfg_ch >= NUM_CH: no state change; cfg_err=1 for exactly the next cycle.
- Per-channel counter:
  - Advances only when enable=1, mode!=off and period!=0.
  - Counts 0..period-1. When counter==period-1 it wraps to 0 and the channel "fires" that cycle.
  - period=1 fires every enabled cycle.
  - period=0 never fires, regardless of mode.
- Fire effect by mode:
  - Mode 1: pulse for that cycle.
  - Mode 2: set pending. Pending holds until irq_ack[bit]=1 on a clk edge. If fire and ack happen in the same cycle, pending stays 1 (fire wins).
  - Mode 3: pulse, then mode becomes off on the same edge, with counter=0.
- irq update: irq[b] <= OR over channels with bit==b of (pulse_this_cycle | pending).
  - Latency is one cycle: a fire in cycle N gives irq high in cycle N+1.
  - Pulses are exactly 1 cycle wide unless the channel fires again.
- Several channels may map to one bit; their contributions are ORed. irq_ack on that bit clears every level channel mapped to it.
- enable=0:
  - counters hold; no new fires
  - pending bits hold, and acks still clear them
  - irq reflects pending only
- Config write while the same channel fires in that cycle: the write wins. The fire is discarded and not counted.
- fire_cnt increments by the number of channels firing in the cycle (0..NUM_CH). It wraps modulo 2^32.
- resetn assertion mid-operation: all state returns to reset values immediately (asynchronous). No irq glitch beyond the async clear.

Optional Feature:
Macro: IRQ_STIM_OVERRUN_EN.
- Defined:
  - Adds an output overrun (1 bit, sticky).
  - Adds a per-channel 8-bit saturating overrun counter, readable as ovr_cnt (NUM_CH*8 bits, channel 0 in LSBs).
  - An overrun is a mode-2 fire while pending is already 1 and not acked in the same cycle. It increments that channel's counter (saturates at 255) and sets overrun=1.
  - A config write to a channel clears that channel's counter.
  - overrun clears only on reset.
- Undefined: ports ovr_cnt and overrun absent; there is no overrun logic.

Test Plan:
- Reset, enable=1, no config → irq=0 for 100 cycles, fire_cnt=0. cfg_ready is 0 during reset and 1 on the first edge after release.
- Ch0 mode1 period=8 bit=4 → irq[4] 1-cycle pulses every 8 cycles. The first pulse comes 8 cycles after the write takes effect, plus 1 cycle latency. fire_cnt=10 after 80 enabled cycles.
- Ch1 mode2 period=5 bit=7, no ack → irq[7] rises and stays high. Assert irq_ack[7] for 1 cycle → irq[7] drops next cycle and rises again at the next fire. An ack coinciding with a fire leaves irq[7] high.
- Ch2 mode3 period=3 bit=0 → a single pulse on irq[0], then none for 50 cycles; readback shows mode off. Then write cfg_ch=NUM_CH → cfg_err pulse of 1 cycle, no state change.
- Ch0 and ch3 both mode1 period=4 bit=5, with enable toggled low for 6 cycles mid-run → no pulses while low; the phase resumes exactly; fire_cnt adds 2 per firing cycle.
- With IRQ_STIM_OVERRUN_EN: ch1 mode2 period=2, no ack for 600 cycles → ovr_cnt[15:8]=255 (saturated) and overrun=1. Reconfiguring ch1 → ovr_cnt[15:8]=0 while overrun stays 1.
